adrv9001_rx_delay_cal: RTL and testbench
========================================

# adrv9001_rx_delay_cal

Receive SSI input-delay calibration controller for one ADRV9001 receive channel. On command it sweeps the shared input-delay tap of the I, Q and strobe lanes through every setting and checks at each tap that the packed strobe word is stable. It finds the longest run of passing taps and loads the centre tap. It runs in the divided SSI clock domain, between the serdes/pack path (strobe source) and the lane delay elements (tap sink).

## Interface
- TAP_WIDTH, 5: tap code width; taps swept 0..2^TAP_WIDTH-1.
- SETTLE_CYCLES, 8: clk cycles waited after each tap load before observing.
- MIN_WINDOW, 4: minimum passing-run length for success.
- TIMEOUT_CYCLES, 65535: max clk cycles in the observe phase of one tap.

- clk  in  1  divided SSI clock (dclk_div domain).
- rstn  in  1  synchronous, active-low reset.
- start  in  1  level-sampled; rising edge in IDLE/DONE starts a sweep.
- dwell  in  16  valid strobe words observed per tap; 0 treated as 1.
- strb_in  in  16  packed strobe word.
- valid_in  in  1  strb_in valid.
- tap_out  out  TAP_WIDTH  tap code to delay elements.
- tap_load  out  1  one-cycle pulse: delay elements load tap_out.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- fail  out  1  sticky result flag: longest run < MIN_WINDOW.
- best_tap  out  TAP_WIDTH  chosen tap.
- window_len  out  TAP_WIDTH+1  length of longest passing run.
- pass_map  out  2^TAP_WIDTH  per-tap result (debug build only).

## Operation
- States: IDLE, LOAD, SETTLE, OBSERVE, EVAL, FINAL, DONE.
- IDLE/DONE: a start rising edge (start=1, previous sample 0) clears the run trackers and fail, sets tap=0, and goes to LOAD. start edges in any other state are ignored.
- LOAD: tap_out=tap, tap_load=1 for one cycle, then go to SETTLE with a counter of SETTLE_CYCLES.
- SETTLE: count down. At 0, go to OBSERVE. The observe counter is set to max(dwell,1), the reference word is cleared, and the timeout counter is cleared.
- OBSERVE: the first valid word becomes the reference. Each later valid word must equal the reference. A word of 16'h0000 or 16'hFFFF fails the tap. Any mismatch also fails the tap. The phase ends when the observe counter reaches 0 or the timeout expires. On timeout the tap fails.
- EVAL: a pass increments cur_len and records cur_start on the first pass of a run. A fail resets cur_len to 0. If cur_len > best_len after the update, best_len and best_start are updated (strict >, so the earliest run wins a tie). If tap is the maximum, go to FINAL; otherwise increment tap and go to LOAD.
- FINAL: best_tap = best_start + (best_len-1)>>1 (floor centre). If best_len=0, best_tap=0. window_len=best_len. fail=(best_len<MIN_WINDOW). Go to LOAD_FINAL behaviour: tap_out=best_tap with a one-cycle tap_load pulse, then go to DONE with done=1 for one cycle.
- The sweep is linear; there is no wrap-around from the maximum tap to 0.
- busy=1 in every state except IDLE and DONE.
- Arithmetic: the centre sum is computed in TAP_WIDTH+1 bits and cannot overflow.

## Timing
- Reset values: tap_out=0, tap_load=0, busy=0, done=0, fail=0, best_tap=0, window_len=0, pass_map=0. State is IDLE.
- Reset mid-sweep: returns to the reset values on the next edge. No final tap_load is issued.
- start edge to first tap_load: 1 cycle. The start edge is registered, and tap_load is asserted in the following cycle.
- Per tap with continuous valid: 1 (LOAD) + SETTLE_CYCLES + max(dwell,1) + 1 (EVAL) cycles.
- best_tap, window_len and fail are valid in the cycle done pulses and held until the next start.
- tap_load is never asserted in consecutive cycles.

## Configuration
- ADRV9001_RX_DELAY_CAL_DBG_EN defined: pass_map[t] is set in EVAL for each passing tap, cleared at start, and held after done.
- Undefined: pass_map is tied to 0 and no map register is generated. All other behaviour is identical.

## Test plan
- Strobe 16'h00FF stable on taps 10..17, random on others, dwell=4 -> best_tap=13, window_len=8, fail=0, exactly 33 tap_load pulses, final tap_out=13.
- Passing runs on taps 2..5 and 20..23 -> tie is resolved to the first run: best_tap=3, window_len=4.
- Passing taps only 0..2, MIN_WINDOW=4 -> fail=1, best_tap=1, window_len=3, done pulses once.
- valid_in held 0 for the whole sweep, TIMEOUT_CYCLES=16 -> every tap fails, best_tap=0, window_len=0, fail=1.
- rstn=0 during OBSERVE of tap 7 -> next cycle: busy=0, tap_out=0, no done. A new start then restarts from tap 0.
- start pulsed again while busy -> ignored; sweep timing is unchanged. With the DBG_EN build, pass_map=32'h0003FC00 for the first scenario.

Source files
------------

// File: rtl/adrv9001_rx_delay_cal_if.sv
// ---------------------------------------------------------------------------
// adrv9001_rx_delay_cal_if
//
// Purpose: groups the command, strobe-input, tap-output and result signals of
//          the receive SSI input-delay calibration controller.
//
// Signals:
//   start      level-sampled sweep request (rising edge starts a sweep)
//   dwell      valid strobe words observed per tap (0 is treated as 1)
//   strb_in    packed strobe word from the serdes/pack path
//   valid_in   strb_in valid
//   tap_out    tap code to the lane delay elements
//   tap_load   one-cycle load pulse for tap_out
//   busy       sweep in progress
//   done       one-cycle pulse at sweep end
//   fail       sticky result flag: longest passing run too short
//   best_tap   chosen (centre) tap
//   window_len length of the longest passing run
//   pass_map   per-tap pass result (zero unless the debug build is used)
//
// Modports:
//   slave   calibration controller view
//   master  system / testbench view
// ---------------------------------------------------------------------------
interface adrv9001_rx_delay_cal_if #(
    parameter int unsigned TAP_WIDTH = 5
);
    logic                        start;
    logic [15:0]                 dwell;
    logic [15:0]                 strb_in;
    logic                        valid_in;
    logic [TAP_WIDTH-1:0]        tap_out;
    logic                        tap_load;
    logic                        busy;
    logic                        done;
    logic                        fail;
    logic [TAP_WIDTH-1:0]        best_tap;
    logic [TAP_WIDTH:0]          window_len;
    logic [(1<<TAP_WIDTH)-1:0]   pass_map;

    modport slave (
        input  start, dwell, strb_in, valid_in,
        output tap_out, tap_load, busy, done, fail, best_tap, window_len, pass_map
    );

    modport master (
        output start, dwell, strb_in, valid_in,
        input  tap_out, tap_load, busy, done, fail, best_tap, window_len, pass_map
    );
endinterface

// File: rtl/adrv9001_rx_delay_cal.sv
// ---------------------------------------------------------------------------
// adrv9001_rx_delay_cal
//
// Purpose: input-delay calibration for one ADRV9001 receive SSI channel.
//          On a start edge the shared I/Q/strobe delay tap is swept linearly
//          from 0 to the maximum. At each tap the packed strobe word is watched
//          for stability; the longest run of passing taps is tracked and its
//          (floor) centre tap is loaded into the delay elements at the end.
//
// Ports:
//   i_clk    divided SSI clock
//   i_rstn   synchronous active-low reset
//   io_cal   adrv9001_rx_delay_cal_if.slave (command, strobe, tap, results)
//
// Build option:
//   ADRV9001_RX_DELAY_CAL_DBG_EN  when defined, a per-tap pass map register is
//                                 kept and driven on pass_map; otherwise
//                                 pass_map is tied to zero.
// ---------------------------------------------------------------------------
module adrv9001_rx_delay_cal #(
    parameter int unsigned TAP_WIDTH      = 5,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned MIN_WINDOW     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    adrv9001_rx_delay_cal_if.slave        io_cal
);

    localparam int unsigned LenW = TAP_WIDTH + 1;
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TAP_WIDTH-1:0] TapMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StObserve,
        StEval,
        StFinal,
        StLoadFinal,
        StDone
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic                   r_start_prev;
    logic [TAP_WIDTH-1:0]   r_tap;
    logic [TAP_WIDTH-1:0]   r_tap_out;
    logic [SetW-1:0]        r_set_cnt;
    logic [15:0]            r_obs_cnt;
    logic [TmoW-1:0]        r_tmo_cnt;
    logic [15:0]            r_ref;
    logic                   r_ref_vld;
    logic                   r_tap_ok;
    logic [LenW-1:0]        r_cur_len;
    logic [TAP_WIDTH-1:0]   r_cur_start;
    logic [LenW-1:0]        r_best_len;
    logic [TAP_WIDTH-1:0]   r_best_start;
    logic [TAP_WIDTH-1:0]   r_best_tap;
    logic [LenW-1:0]        r_window_len;
    logic                   r_fail;

    logic                   w_start_edge;
    logic                   w_sweep_start;
    logic [15:0]            w_dwell_eff;
    logic                   w_word_bad;
    logic                   w_obs_last;
    logic                   w_tmo;
    logic [LenW-1:0]        w_cur_len_upd;
    logic [TAP_WIDTH-1:0]   w_run_start;
    logic [LenW-1:0]        w_centre;
    logic [TAP_WIDTH-1:0]   w_final_tap;
    logic                   w_tap_load;
    logic                   w_busy;
    logic                   w_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    assign w_start_edge  = io_cal.start & ~r_start_prev;
    assign w_sweep_start = w_start_edge && ((r_state == StIdle) || (r_state == StDone));
    assign w_dwell_eff   = (io_cal.dwell == 16'd0) ? 16'd1 : io_cal.dwell;

    // All-zero / all-one words mean the strobe is not toggling at this tap.
    assign w_word_bad = (io_cal.strb_in == 16'h0000) || (io_cal.strb_in == 16'hFFFF) ||
                        (r_ref_vld && (io_cal.strb_in != r_ref));
    assign w_obs_last = io_cal.valid_in && (r_obs_cnt == 16'd1);
    assign w_tmo      = (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) && !w_obs_last;

    assign w_cur_len_upd = r_tap_ok ? (r_cur_len + LenW'(1)) : '0;
    assign w_run_start   = (r_cur_len == '0) ? r_tap : r_cur_start;

    // Floor centre of the best run, one extra bit so the sum cannot wrap.
    assign w_centre    = LenW'(r_best_start) + ((r_best_len - LenW'(1)) >> 1);
    assign w_final_tap = (r_best_len == '0) ? '0 : w_centre[TAP_WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:      if (w_start_edge) w_state_next = StLoad;
            StDone:      w_state_next = w_start_edge ? StLoad : StIdle;
            StLoad:      w_state_next = StSettle;
            StSettle:    if (r_set_cnt <= SetW'(1)) w_state_next = StObserve;
            StObserve:   if (w_obs_last || w_tmo) w_state_next = StEval;
            StEval:      w_state_next = (r_tap == TapMax) ? StFinal : StLoad;
            StFinal:     w_state_next = StLoadFinal;
            StLoadFinal: w_state_next = StDone;
            default:     w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_tap_load = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        unique case (r_state)
            StIdle:              w_busy = 1'b0;
            StDone: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            StLoad, StLoadFinal: w_tap_load = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_start_prev <= 1'b0;
            r_tap        <= '0;
            r_tap_out    <= '0;
            r_set_cnt    <= '0;
            r_obs_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_ref        <= '0;
            r_ref_vld    <= 1'b0;
            r_tap_ok     <= 1'b0;
            r_cur_len    <= '0;
            r_cur_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_best_tap   <= '0;
            r_window_len <= '0;
            r_fail       <= 1'b0;
        end else begin
            r_start_prev <= io_cal.start;
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_start_edge) begin
                        r_tap        <= '0;
                        r_tap_out    <= '0;
                        r_cur_len    <= '0;
                        r_cur_start  <= '0;
                        r_best_len   <= '0;
                        r_best_start <= '0;
                        r_fail       <= 1'b0;
                    end
                end
                StLoad: begin
                    r_set_cnt <= SetW'(SETTLE_CYCLES);
                end
                StSettle: begin
                    r_set_cnt <= r_set_cnt - SetW'(1);
                    if (r_set_cnt <= SetW'(1)) begin
                        r_obs_cnt <= w_dwell_eff;
                        r_ref     <= '0;
                        r_ref_vld <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_tap_ok  <= 1'b1;
                    end
                end
                StObserve: begin
                    r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
                    if (io_cal.valid_in) begin
                        r_obs_cnt <= r_obs_cnt - 16'd1;
                        if (w_word_bad) r_tap_ok <= 1'b0;
                        if (!r_ref_vld) begin
                            r_ref     <= io_cal.strb_in;
                            r_ref_vld <= 1'b1;
                        end
                    end
                    if (w_tmo) r_tap_ok <= 1'b0;
                end
                StEval: begin
                    r_cur_len <= w_cur_len_upd;
                    if (r_tap_ok && (r_cur_len == '0)) r_cur_start <= r_tap;
                    // Strict compare: on a tie the earlier run is kept.
                    if (w_cur_len_upd > r_best_len) begin
                        r_best_len   <= w_cur_len_upd;
                        r_best_start <= w_run_start;
                    end
                    if (r_tap != TapMax) begin
                        r_tap     <= r_tap + TAP_WIDTH'(1);
                        r_tap_out <= r_tap + TAP_WIDTH'(1);
                    end
                end
                StFinal: begin
                    r_best_tap   <= w_final_tap;
                    r_tap_out    <= w_final_tap;
                    r_window_len <= r_best_len;
                    r_fail       <= (32'(r_best_len) < MIN_WINDOW);
                end
                StLoadFinal: ;
                default: ;
            endcase
        end
    end

`ifdef ADRV9001_RX_DELAY_CAL_DBG_EN
    logic [(1<<TAP_WIDTH)-1:0] r_pass_map;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pass_map <= '0;
        end else if (w_sweep_start) begin
            r_pass_map <= '0;
        end else if ((r_state == StEval) && r_tap_ok) begin
            r_pass_map[r_tap] <= 1'b1;
        end
    end

    assign io_cal.pass_map = r_pass_map;
`else
    assign io_cal.pass_map = '0;
`endif

    assign io_cal.tap_out    = r_tap_out;
    assign io_cal.tap_load   = w_tap_load;
    assign io_cal.busy       = w_busy;
    assign io_cal.done       = w_done;
    assign io_cal.fail       = r_fail;
    assign io_cal.best_tap   = r_best_tap;
    assign io_cal.window_len = r_window_len;

endmodule

// File: tb/tb_adrv9001_rx_delay_cal.sv
// ---------------------------------------------------------------------------
// tb_adrv9001_rx_delay_cal
//
// Purpose: directed self-checking bench for adrv9001_rx_delay_cal.
//          A strobe source returns 16'h00FF on "good" taps and random words
//          elsewhere, so the expected window is fixed by the chosen mask.
// ---------------------------------------------------------------------------
module tb_adrv9001_rx_delay_cal;

    logic        clk;
    logic        rstn;
    logic [31:0] good_mask;
    int          n_checks;
    int          n_errors;
    int          load_cnt;
    int          done_cnt;
    int          consec_cnt;
    logic        prev_load;

    adrv9001_rx_delay_cal_if #(.TAP_WIDTH(5)) cal_if ();

    adrv9001_rx_delay_cal #(
        .TAP_WIDTH      (5),
        .SETTLE_CYCLES  (8),
        .MIN_WINDOW     (4),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_cal (cal_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe source: stable pattern on good taps, random elsewhere.
    always @(negedge clk) begin
        if (good_mask[cal_if.tap_out]) cal_if.strb_in = 16'h00FF;
        else                           cal_if.strb_in = 16'($urandom);
    end

    // Pulse monitor for tap_load / done.
    initial begin
        load_cnt   = 0;
        done_cnt   = 0;
        consec_cnt = 0;
        prev_load  = 1'b0;
    end
    always @(negedge clk) begin
        if (cal_if.tap_load) load_cnt = load_cnt + 1;
        if (cal_if.tap_load && prev_load) consec_cnt = consec_cnt + 1;
        if (cal_if.done) done_cnt = done_cnt + 1;
        prev_load = cal_if.tap_load;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise start, check the first tap_load, count cycles until done.
    task automatic run_sweep(input bit glitch, output int cycles);
        @(negedge clk);
        cal_if.start = 1'b1;
        @(posedge clk);
        #1;
        check("first_load", {26'd0, cal_if.tap_load, cal_if.tap_out}, {26'd0, 1'b1, 5'd0});
        cycles = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
            if (glitch && cycles == 100) cal_if.start = 1'b0;
            if (glitch && cycles == 102) cal_if.start = 1'b1;
            if (cal_if.done) break;
            if (cycles > 5000) begin
                check("sweep_done", {31'd0, cal_if.done}, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int exp_best, input int exp_len,
                                input int exp_fail);
        check({tag, "_best"}, {27'd0, cal_if.best_tap}, exp_best);
        check({tag, "_len"}, {26'd0, cal_if.window_len}, exp_len);
        check({tag, "_fail"}, {31'd0, cal_if.fail}, exp_fail);
        check({tag, "_tapout"}, {27'd0, cal_if.tap_out}, exp_best);
    endtask

    initial begin
        int cyc;
        int loads0;
        int dones0;
        int guard;

        n_checks        = 0;
        n_errors        = 0;
        rstn            = 1'b0;
        good_mask       = 32'h0;
        cal_if.start    = 1'b0;
        cal_if.dwell    = 16'd4;
        cal_if.valid_in = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tap_out", {27'd0, cal_if.tap_out}, 32'd0);
        check("rst_tap_load", {31'd0, cal_if.tap_load}, 32'd0);
        check("rst_busy", {31'd0, cal_if.busy}, 32'd0);
        check("rst_done", {31'd0, cal_if.done}, 32'd0);
        check("rst_fail", {31'd0, cal_if.fail}, 32'd0);
        check("rst_best", {27'd0, cal_if.best_tap}, 32'd0);
        check("rst_len", {26'd0, cal_if.window_len}, 32'd0);
        check("rst_map", cal_if.pass_map, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Window on taps 10..17, start re-pulsed mid-sweep (must be ignored)
        good_mask = 32'h0003FC00;
        loads0 = load_cnt;
        run_sweep(1'b1, cyc);
        check("t1_cycles", cyc, 32'd450);
        check_result("t1", 13, 8, 0);
`ifdef ADRV9001_RX_DELAY_CAL_DBG_EN
        check("t1_map", cal_if.pass_map, 32'h0003FC00);
`else
        check("t1_map", cal_if.pass_map, 32'h0);
`endif
        cal_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_loads", load_cnt - loads0, 32'd33);
        check("t1_busy_after", {31'd0, cal_if.busy}, 32'd0);
        check("t1_best_held", {27'd0, cal_if.best_tap}, 32'd13);

        // Two equal runs: earliest wins
        good_mask = 32'h00F0003C;
        run_sweep(1'b0, cyc);
        check_result("t2", 3, 4, 0);
        cal_if.start = 1'b0;
        repeat (2) @(negedge clk);

        // Short window at the bottom edge
        good_mask = 32'h00000007;
        dones0 = done_cnt;
        run_sweep(1'b0, cyc);
        check_result("t3", 1, 3, 1);
        cal_if.start = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_done_once", done_cnt - dones0, 32'd1);
        check("t3_fail_held", {31'd0, cal_if.fail}, 32'd1);

        // No valid words: every tap times out (1 + 8 + 16 + 1 per tap)
        good_mask = 32'hFFFFFFFF;
        cal_if.valid_in = 1'b0;
        run_sweep(1'b0, cyc);
        check("t4_cycles", cyc, 32'd834);
        check_result("t4", 0, 0, 1);
        cal_if.start = 1'b0;
        cal_if.valid_in = 1'b1;
        repeat (2) @(negedge clk);

        // dwell = 0 behaves as 1 (1 + 8 + 1 + 1 per tap)
        cal_if.dwell = 16'd0;
        good_mask = 32'h0003FC00;
        run_sweep(1'b0, cyc);
        check("t5_cycles", cyc, 32'd354);
        cal_if.start = 1'b0;
        cal_if.dwell = 16'd4;
        repeat (2) @(negedge clk);

        // Reset during OBSERVE of tap 7
        @(negedge clk);
        cal_if.start = 1'b1;
        guard = 0;
        while (!(cal_if.tap_load && cal_if.tap_out == 5'd7) && guard < 1000) begin
            @(negedge clk);
            guard = guard + 1;
        end
        check("t6_reached_tap7", {27'd0, cal_if.tap_out}, 32'd7);
        repeat (10) @(negedge clk);
        check("t6_busy_before", {31'd0, cal_if.busy}, 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("t6_busy", {31'd0, cal_if.busy}, 32'd0);
        check("t6_tap_out", {27'd0, cal_if.tap_out}, 32'd0);
        check("t6_done", {31'd0, cal_if.done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cal_if.start = 1'b0;
        loads0 = load_cnt;
        dones0 = done_cnt;
        repeat (5) @(negedge clk);
        check("t6_no_load", load_cnt - loads0, 32'd0);
        check("t6_no_done", done_cnt - dones0, 32'd0);
        run_sweep(1'b0, cyc);
        check("t6_cycles", cyc, 32'd450);
        check_result("t6", 13, 8, 0);
        cal_if.start = 1'b0;
        repeat (3) @(negedge clk);

        check("no_consec_load", consec_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
